// File: rtl/lcd_hd44780_driver.sv
// lcd_hd44780_driver
// Turns each strobe toggle in the LCD register word into one timed HD44780
// write cycle (setup, enable pulse, hold, execution wait). It keeps a one-deep
// pending buffer behind the active write, where the newest request wins.
// Busy and overrun status are registered.
module lcd_hd44780_driver #(
    parameter int T_PWRUP      = 2000000,
    parameter int T_SETUP      = 3,
    parameter int T_PULSE      = 25,
    parameter int T_HOLD       = 3,
    parameter int T_EXEC_SHORT = 2000,
    parameter int T_EXEC_LONG  = 76000,
    parameter int CNT_W        = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_busy,
    output logic        o_lcd_overrun
);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_t;

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_EXEC_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic             tog_seen;
    logic             act_rs, act_rs_next;
    logic [7:0]       act_data, act_data_next;
    logic             pend_valid, pend_valid_next;
    logic             pend_rs, pend_rs_next;
    logic [7:0]       pend_data, pend_data_next;
    logic             busy_next;
    logic             overrun_next;

    logic             req;
    logic             cnt_zero;
    logic             exec_long;
    logic             exec_done;
    logic             req_rs;
    logic [7:0]       req_data;
    logic             unused_reg_bits;

    assign req_rs          = i_lcd_reg[9];
    assign req_data        = i_lcd_reg[7:0];
    assign unused_reg_bits = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

    // A toggle is only honoured once the power-up wait has finished.
    assign req       = (i_lcd_reg[10] != tog_seen) && (state != ST_PWRUP);
    assign cnt_zero  = (counter == '0);
    assign exec_done = (state == ST_EXEC) && cnt_zero;
    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign exec_long = !act_rs && (act_data == 8'h01 || act_data == 8'h02 || act_data == 8'h03);

    // Next-state, counter, active/pending buffer and status computation.
    always_comb begin
        state_next      = state;
        counter_next    = counter;
        act_rs_next     = act_rs;
        act_data_next   = act_data;
        pend_valid_next = pend_valid;
        pend_rs_next    = pend_rs;
        pend_data_next  = pend_data;
        overrun_next    = 1'b0;

        case (state)
            ST_PWRUP: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req) begin
                    act_rs_next   = req_rs;
                    act_data_next = req_data;
                    counter_next  = LD_SETUP;
                    state_next    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    counter_next = LD_PULSE;
                    state_next   = ST_PULSE;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    counter_next = LD_HOLD;
                    state_next   = ST_HOLD;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    counter_next = exec_long ? LD_LONG : LD_SHORT;
                    state_next   = ST_EXEC;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    if (pend_valid) begin
                        act_rs_next     = pend_rs;
                        act_data_next   = pend_data;
                        pend_valid_next = 1'b0;
                        counter_next    = LD_SETUP;
                        state_next      = ST_SETUP;
                        if (req) begin
                            pend_rs_next    = req_rs;
                            pend_data_next  = req_data;
                            pend_valid_next = 1'b1;
                        end
                    end else if (req) begin
                        act_rs_next   = req_rs;
                        act_data_next = req_data;
                        counter_next  = LD_SETUP;
                        state_next    = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            default: begin
                state_next   = ST_PWRUP;
                counter_next = LD_PWRUP;
            end
        endcase

        if (req && !exec_done &&
            (state == ST_SETUP || state == ST_PULSE || state == ST_HOLD || state == ST_EXEC)) begin
            overrun_next    = pend_valid;
            pend_rs_next    = req_rs;
            pend_data_next  = req_data;
            pend_valid_next = 1'b1;
        end

        busy_next = (state_next != ST_IDLE) || pend_valid_next;
    end

    // State, counter, buffers and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_PWRUP;
            counter       <= LD_PWRUP;
            tog_seen      <= 1'b0;
            act_rs        <= 1'b0;
            act_data      <= 8'h00;
            pend_valid    <= 1'b0;
            pend_rs       <= 1'b0;
            pend_data     <= 8'h00;
            o_lcd_on      <= 1'b0;
            o_lcd_busy    <= 1'b0;
            o_lcd_overrun <= 1'b0;
        end else begin
            state         <= state_next;
            counter       <= counter_next;
            tog_seen      <= i_lcd_reg[10];
            act_rs        <= act_rs_next;
            act_data      <= act_data_next;
            pend_valid    <= pend_valid_next;
            pend_rs       <= pend_rs_next;
            pend_data     <= pend_data_next;
            o_lcd_on      <= i_lcd_reg[31];
            o_lcd_busy    <= busy_next;
            o_lcd_overrun <= overrun_next;
        end
    end

    assign o_lcd_en   = (state == ST_PULSE);
    assign o_lcd_rs   = act_rs;
    assign o_lcd_data = act_data;
    assign o_lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// tb_lcd_hd44780_driver
// Directed and randomized stimulus against a cycle-level reference model of
// the LCD write protocol. Expected writes are queued by the model and popped
// by a monitor at each rising edge of EN.
module tb_lcd_hd44780_driver;

    localparam int T_PWRUP      = 10;
    localparam int T_SETUP      = 2;
    localparam int T_PULSE      = 4;
    localparam int T_HOLD       = 2;
    localparam int T_EXEC_SHORT = 8;
    localparam int T_EXEC_LONG  = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_busy, lcd_overrun;
    logic [7:0]  lcd_data;

    lcd_hd44780_driver #(
        .T_PWRUP      (T_PWRUP),
        .T_SETUP      (T_SETUP),
        .T_PULSE      (T_PULSE),
        .T_HOLD       (T_HOLD),
        .T_EXEC_SHORT (T_EXEC_SHORT),
        .T_EXEC_LONG  (T_EXEC_LONG),
        .CNT_W        (32)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_lcd_reg     (lcd_reg),
        .o_lcd_on      (lcd_on),
        .o_lcd_en      (lcd_en),
        .o_lcd_rs      (lcd_rs),
        .o_lcd_rw      (lcd_rw),
        .o_lcd_data    (lcd_data),
        .o_lcd_busy    (lcd_busy),
        .o_lcd_overrun (lcd_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       rs;
        bit [7:0] data;
        int       en_edge;
    } wr_t;

    wr_t exp_q[$];

    // Reference model state, indexed by clock edges since reset release.
    int       m_t;
    bit       m_active;
    int       m_start;
    int       m_end;
    bit       m_act_rs;
    bit [7:0] m_act_data;
    bit       m_pend;
    bit       m_pend_rs;
    bit [7:0] m_pend_data;
    bit       m_last_tog;
    bit       m_on;
    bit       m_ovr;

    bit       tog;
    bit       on_bit;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, m_t, actual, expected);
        end
    endtask

    function automatic int writeLength(bit rs, bit [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            return T_SETUP + T_PULSE + T_HOLD + T_EXEC_LONG;
        return T_SETUP + T_PULSE + T_HOLD + T_EXEC_SHORT;
    endfunction

    function automatic void startWrite(bit rs, bit [7:0] d);
        wr_t w;
        m_active   = 1'b1;
        m_start    = m_t;
        m_end      = m_t + writeLength(rs, d);
        m_act_rs   = rs;
        m_act_data = d;
        w.rs       = rs;
        w.data     = d;
        w.en_edge  = m_t + T_SETUP;
        exp_q.push_back(w);
    endfunction

    function automatic void modelReset();
        m_t        = 0;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_act_rs   = 1'b0;
        m_act_data = 8'h00;
        m_on       = 1'b0;
        m_ovr      = 1'b0;
        exp_q.delete();
    endfunction

    // Advance the model by one clock edge with the word sampled at that edge.
    function automatic void modelStep(logic [31:0] word);
        bit req;
        m_t++;
        m_ovr = 1'b0;
        m_on  = word[31];
        if (m_active && m_t == m_end) begin
            if (m_pend) begin
                m_pend = 1'b0;
                startWrite(m_pend_rs, m_pend_data);
            end else begin
                m_active = 1'b0;
            end
        end
        req        = (m_t > T_PWRUP) && (word[10] != m_last_tog);
        m_last_tog = word[10];
        if (req) begin
            if (!m_active) begin
                startWrite(word[9], word[7:0]);
            end else begin
                if (m_pend) m_ovr = 1'b1;
                m_pend      = 1'b1;
                m_pend_rs   = word[9];
                m_pend_data = word[7:0];
            end
        end
    endfunction

    function automatic logic [31:0] makeWord(bit on, bit tg, bit rs, bit [7:0] d);
        logic [31:0] r;
        r = $urandom();
        return {on, r[30:11], tg, rs, r[8], d};
    endfunction

    task automatic checkOutput();
        int  age;
        bit  exp_en;
        bit  exp_busy;
        age      = m_t - m_start;
        exp_en   = m_active && age >= T_SETUP && age < T_SETUP + T_PULSE;
        exp_busy = (m_t >= 1 && m_t < T_PWRUP) || m_active || m_pend;
        check("en",      32'(lcd_en),      32'(exp_en));
        check("busy",    32'(lcd_busy),    32'(exp_busy));
        check("rs",      32'(lcd_rs),      32'(m_act_rs));
        check("data",    32'(lcd_data),    32'(m_act_data));
        check("overrun", 32'(lcd_overrun), 32'(m_ovr));
        check("on",      32'(lcd_on),      32'(m_on));
        check("rw",      32'(lcd_rw),      32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        lcd_reg = word;
        modelStep(word);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic writeWord(input bit rs, input bit [7:0] d);
        tog = ~tog;
        applyStimulus(makeWord(on_bit, tog, rs, d));
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(makeWord(on_bit, tog, 1'($urandom_range(0, 1)), 8'($urandom())));
    endtask

    // Monitor: each rising edge of EN must match the oldest expected write.
    initial begin : monitor
        int  edge_n;
        bit  prev_en;
        wr_t w;
        edge_n  = 0;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                edge_n  = 0;
                prev_en = 1'b0;
            end else begin
                edge_n++;
                if (lcd_en && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL wr_unexpected at edge %0d: got write rs=%0b data=%0h, expected none",
                                 edge_n, lcd_rs, lcd_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_rs",   32'(lcd_rs),   32'(w.rs));
                        check("wr_data", 32'(lcd_data), 32'(w.data));
                        check("wr_edge", 32'(edge_n),   32'(w.en_edge));
                    end
                end
                prev_en = lcd_en;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int first;
        int guard;
        lcd_reg = 32'h8000_0400;
        tog     = 1'b1;
        on_bit  = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] power-up with toggle already set");
        repeat (14) applyStimulus(32'h8000_0400);

        $display("[TB] single data write");
        tog = 1'b0;
        applyStimulus(32'h8000_0241);
        idle(20);

        $display("[TB] clear display and function set");
        writeWord(1'b0, 8'h01);
        idle(50);
        writeWord(1'b0, 8'h38);
        idle(20);

        $display("[TB] overrun on third toggle");
        writeWord(1'b1, 8'h41);
        writeWord(1'b1, 8'h42);
        writeWord(1'b1, 8'h43);
        idle(40);

        $display("[TB] toggle on final execution cycle");
        writeWord(1'b1, 8'h41);
        first = m_t;
        writeWord(1'b1, 8'h42);
        idle(first + 16 - m_t - 1);
        writeWord(1'b1, 8'h44);
        idle(40);

        $display("[TB] reset during enable pulse");
        writeWord(1'b1, 8'h55);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_en",   32'(lcd_en),   32'd0);
        check("rst_rs",   32'(lcd_rs),   32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_busy", 32'(lcd_busy), 32'd0);
        tog     = ~tog;
        lcd_reg = makeWord(on_bit, tog, 1'b1, 8'h77);
        @(negedge clk);
        @(negedge clk);
        modelReset();
        checkOutput();
        rst_n = 1'b1;
        idle(4);
        writeWord(1'b1, 8'h66);
        idle(10);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bit       rs;
                bit [7:0] d;
                rs = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
                else d = 8'($urandom());
                if ($urandom_range(0, 7) == 0) on_bit = ~on_bit;
                writeWord(rs, d);
            end else begin
                idle(1);
            end
        end

        guard = 0;
        while ((m_active || m_pend) && guard < 500) begin
            idle(1);
            guard++;
        end
        idle(5);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_driver.md
Name: lcd_hd44780_driver

Overview:
- Consumes the 32-bit LCD register word that the load-store unit exposes on its LCD output and generates HD44780-compatible bus timing for the DE2-class character LCD.
- Software writes one command or character per register store and toggles the strobe bit; this block turns each toggle into a timed write cycle.
- Provides a one-deep pending buffer, busy status, and an overrun flag.
- Write-only: RW is always 0 and the LCD busy flag is never polled.

Parameters:
- T_PWRUP, 2000000: cycles held in power-up wait after reset (40 ms at 50 MHz).
- T_SETUP, 3: cycles RS/DATA are stable before EN rises.
- T_PULSE, 25: cycles EN is held high.
- T_HOLD, 3: cycles RS/DATA are held after EN falls.
- T_EXEC_SHORT, 2000: post-write wait for normal commands and data (≥37 µs).
- T_EXEC_LONG, 76000: post-write wait for clear/home (≥1.52 ms).
- CNT_W, 32: width of the timing counter.

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: asynchronous active-low reset.
- i_lcd_reg, input, 32: LCD register word. Bit fields: [31] ON, [10] STROBE toggle, [9] RS, [7:0] DATA. All other bits are ignored.
- o_lcd_on, output, 1: LCD power/backlight enable.
- o_lcd_en, output, 1: HD44780 E.
- o_lcd_rs, output, 1: HD44780 RS.
- o_lcd_rw, output, 1: HD44780 RW, constant 0.
- o_lcd_data, output, 8: HD44780 DB[7:0].
- o_lcd_busy, output, 1: high while a request is active or pending.
- o_lcd_overrun, output, 1: one-cycle pulse when the pending request is overwritten.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-low. All flops clear on negedge i_reset.
- Reset values: state=PWRUP; counter=T_PWRUP-1; all outputs 0; pending_valid=0; tog_seen=0.
- o_lcd_on is registered: o_lcd_on <= i_lcd_reg[31] every cycle, including during PWRUP.
- Strobe detect: a request is raised at a posedge where i_lcd_reg[10] != tog_seen and state != PWRUP. On that edge tog_seen <= i_lcd_reg[10].
- PWRUP: tog_seen <= i_lcd_reg[10] every cycle, so toggles during PWRUP are discarded. Counter decrements; at 0 go to IDLE. o_lcd_busy=1.
- IDLE, request seen: latch {RS, DATA} into the active register, load counter=T_SETUP-1, go to SETUP. Outputs drive the new RS/DATA from the next cycle.
- SETUP: en=0. At counter 0, load T_PULSE-1 and go to PULSE.
- PULSE: en=1. At counter 0, load T_HOLD-1 and go to HOLD.
- HOLD: en=0, RS/DATA held. At counter 0, load the exec count and go to EXEC.
  - Exec count is T_EXEC_LONG-1 when RS=0 and DATA ∈ {0x01, 0x02, 0x03}.
  - Otherwise it is T_EXEC_SHORT-1.
- EXEC: en=0. At counter 0:
  - If pending_valid, move pending into active, clear pending_valid, load T_SETUP-1, go to SETUP (no IDLE cycle).
  - Otherwise go to IDLE.
- Requests while state ∈ {SETUP, PULSE, HOLD, EXEC}:
  - If pending_valid=0: store {RS, DATA} in pending, set pending_valid=1.
  - If pending_valid=1: overwrite pending (newest wins) and pulse o_lcd_overrun high for exactly that cycle.
- Simultaneous request and EXEC completion with a pending entry: the promoted pending entry becomes active; the new request goes into the now-free pending slot with no overrun.
- Simultaneous request and EXEC completion with no pending entry: the new request is latched directly as active and the FSM goes to SETUP.
- o_lcd_busy = (state != IDLE) | pending_valid, registered-equivalent (derived from flops only).
- RS/DATA outputs change only on entry to SETUP. They are stable throughout SETUP, PULSE, HOLD, and EXEC.
- Busy duration per write, from the latch edge: T_SETUP + T_PULSE + T_HOLD + T_EXEC cycles, then IDLE.
- Reset asserted mid-operation: immediate return to reset values, en=0, pending discarded. Any toggle present at reset release is absorbed by PWRUP tracking.

Test Plan (sim params: T_PWRUP=10, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC_SHORT=8, T_EXEC_LONG=40):
- Reset, then hold i_lcd_reg=0x8000_0400 (toggle already 1) → no EN pulse ever. busy=1 for 10 cycles then 0. o_lcd_on=1 one cycle after sampling.
- After PWRUP, write 0x8000_0241 (RS=1, DATA=0x41, toggle→0... flip bit10) → RS=1 and DATA=0x41 on the next cycle. EN low 2 cycles, high 4, low 2. busy drops 16 cycles after the latch edge.
- RS=0, DATA=0x01 (clear) → EN pulse as above, then 40-cycle EXEC; busy total 48 cycles. Same check with DATA=0x38 → 16 cycles.
- Three toggles during one active write: DATA 0x41 active, then 0x42, 0x43 → one overrun pulse on the third toggle. Active 0x41 completes, then 0x43 starts with no IDLE gap. 0x42 never appears on o_lcd_data.
- Toggle exactly on the EXEC-final cycle with pending 0x42 → 0x42 active, new 0x44 pending, no overrun, both written in order.
- Assert i_reset during PULSE → en, rs, data, busy go to 0 asynchronously. After release, the PWRUP wait repeats and no stale write occurs.
